// File: rtl/mips_debug_unit_if.sv
// rtl/mips_debug_unit_if.sv - UART byte-stream bundle between the debug unit and the UART pair
interface mips_debug_unit_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output tx_busy,
    input  tx_data,
    input  tx_start
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_busy,
    output tx_data,
    output tx_start
  );
endinterface

// File: rtl/mips_debug_unit.sv
// rtl/mips_debug_unit.sv - command decoder, core clock gating and PC/register dump over UART
module mips_debug_unit #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  mips_debug_unit_if.slave    uart,
  output logic                core_en,
  input  logic                halt_detected,
  input  logic [DATA_W-1:0]   pc,
  output logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_data,
  output logic                busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WCW   = $clog2(NREGS + 1);

  localparam logic [BCW-1:0]    LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [WCW-1:0]    LAST_WORD = WCW'(NREGS);
  localparam logic [BCW-1:0]    BYTE_ONE  = BCW'(1);
  localparam logic [WCW-1:0]    WORD_ONE  = WCW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_HALT = 8'h48;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_STEP      = 3'd2;
  localparam logic [2:0] S_DUMP_LOAD = 3'd3;
  localparam logic [2:0] S_DUMP_SEND = 3'd4;
  localparam logic [2:0] S_DUMP_WAIT = 3'd5;

  logic [2:0]        state;
  logic [DATA_W-1:0] shift;
  logic [BCW-1:0]    byte_cnt;
  logic [WCW-1:0]    word_cnt;
  logic              skip;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      core_en       <= 1'b0;
      uart.tx_start <= 1'b0;
      uart.tx_data  <= 8'h00;
      dbg_addr      <= '0;
      shift         <= '0;
      byte_cnt      <= '0;
      word_cnt      <= '0;
      skip          <= 1'b0;
    end else begin
      uart.tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (uart.rx_valid) begin
            case (uart.rx_data)
              CMD_RUN:  begin state <= S_RUN;  core_en <= 1'b1; end
              CMD_STEP: begin state <= S_STEP; core_en <= 1'b1; end
              CMD_DUMP: state <= S_DUMP_LOAD;
              default:  ;
            endcase
          end
        end
        // A halt seen in the same cycle as 'H' must still produce the dump.
        S_RUN: begin
          if (halt_detected) begin
            core_en <= 1'b0;
            state   <= S_DUMP_LOAD;
          end else if (uart.rx_valid && uart.rx_data == CMD_HALT) begin
            core_en <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_STEP: begin
          core_en <= 1'b0;
          state   <= S_DUMP_LOAD;
        end
        S_DUMP_LOAD: begin
          shift    <= (word_cnt == '0) ? pc : dbg_data;
          byte_cnt <= '0;
          state    <= S_DUMP_SEND;
        end
        S_DUMP_SEND: begin
          if (!uart.tx_busy) begin
            uart.tx_data  <= shift[DATA_W-1 -: 8];
            shift         <= shift << 8;
            uart.tx_start <= 1'b1;
            skip          <= 1'b1;
            state         <= S_DUMP_WAIT;
          end
        end
        // tx_busy lags tx_start by a cycle, so the first wait cycle is ignored.
        S_DUMP_WAIT: begin
          if (skip) begin
            skip <= 1'b0;
          end else if (!uart.tx_busy) begin
            if (byte_cnt != LAST_BYTE) begin
              byte_cnt <= byte_cnt + BYTE_ONE;
              state    <= S_DUMP_SEND;
            end else if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              dbg_addr <= '0;
              state    <= S_IDLE;
            end else begin
              if (word_cnt != '0) dbg_addr <= dbg_addr + ADDR_ONE;
              word_cnt <= word_cnt + WORD_ONE;
              state    <= S_DUMP_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
